// File: rtl/token_multiplier.sv
// Serial token expander: each '1' on a credits FACTOR output tokens, emitted one per
// cycle on b while ready is high. Pending credit saturates at MAX with a sticky overflow flag.
module token_multiplier #(
  parameter int FACTOR = 2,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             ready,
  input  logic             clr,
  output logic             b,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int MAX = 2**CNT_W - 1;

  if (FACTOR < 1 || FACTOR > MAX) begin : g_bad_factor
    $error("token_multiplier: FACTOR must be in 1..2**CNT_W-1");
  end

  // One extra bit so cnt + FACTOR can never wrap before the saturation test.
  localparam logic [CNT_W:0] FACTOR_X = (CNT_W+1)'(FACTOR);
  localparam logic [CNT_W:0] MAX_X    = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [CNT_W:0]   total;
  logic [CNT_W:0]   nxt;
  logic             emit;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    total = {1'b0, cnt};
    if (a) total = total + FACTOR_X;
    emit = ready & ~clr & (total != '0);
    nxt  = total - {{CNT_W{1'b0}}, emit};
  end

  // NOTE: state uses non-blocking assignments; the async reset is in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (nxt > MAX_X) begin
      cnt <= MAX_X[CNT_W-1:0];
      ovf <= 1'b1;
    end else begin
      cnt <= nxt[CNT_W-1:0];
    end
  end

  // b is combinational so an incoming token can leave in the same cycle it arrives.
  assign b        = emit;
  assign pending  = cnt;
  assign busy     = (cnt != '0);
  assign overflow = ovf;

endmodule

// File: tb/tb_token_multiplier.sv
// Scoreboard bench for token_multiplier: four instances (F2/W4, F2/W2, F1/W4, F3/W4),
// directed vectors pushed as expected per-cycle records, checked by an independent monitor.
module tb_token_multiplier;

  typedef struct {
    int    inst;
    logic  eb;
    int    epend;
    logic  eovf;
    string name;
  } exp_t;

  logic clk;
  logic rst;
  logic a_v[4];
  logic r_v[4];
  logic c_v[4];
  logic b_v[4];
  logic busy_v[4];
  logic ovf_v[4];
  logic [3:0] p0;
  logic [1:0] p1;
  logic [3:0] p2;
  logic [3:0] p3;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   sum_b3 = 0;

  token_multiplier #(.FACTOR(2), .CNT_W(4)) u_f2 (
    .clk(clk), .rst(rst), .a(a_v[0]), .ready(r_v[0]), .clr(c_v[0]),
    .b(b_v[0]), .pending(p0), .busy(busy_v[0]), .overflow(ovf_v[0]));
  token_multiplier #(.FACTOR(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .a(a_v[1]), .ready(r_v[1]), .clr(c_v[1]),
    .b(b_v[1]), .pending(p1), .busy(busy_v[1]), .overflow(ovf_v[1]));
  token_multiplier #(.FACTOR(1), .CNT_W(4)) u_f1 (
    .clk(clk), .rst(rst), .a(a_v[2]), .ready(r_v[2]), .clr(c_v[2]),
    .b(b_v[2]), .pending(p2), .busy(busy_v[2]), .overflow(ovf_v[2]));
  token_multiplier #(.FACTOR(3), .CNT_W(4)) u_f3 (
    .clk(clk), .rst(rst), .a(a_v[3]), .ready(r_v[3]), .clr(c_v[3]),
    .b(b_v[3]), .pending(p3), .busy(busy_v[3]), .overflow(ovf_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pend_of(input int inst);
    case (inst)
      0:       return int'(p0);
      1:       return int'(p1);
      2:       return int'(p2);
      default: return int'(p3);
    endcase
  endfunction

  // Monitor: everything seen at the falling edge describes the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.inst == 3 && b_v[3]) sum_b3++;
        check({e.name, ".b"},        int'(b_v[e.inst]),    int'(e.eb));
        check({e.name, ".pending"},  pend_of(e.inst),      e.epend);
        check({e.name, ".busy"},     int'(busy_v[e.inst]), int'(e.epend != 0));
        check({e.name, ".overflow"}, int'(ovf_v[e.inst]),  int'(e.eovf));
      end
    end
  end

  task automatic drive(input int inst, input logic av, input logic rv, input logic cv);
    for (int i = 0; i < 4; i++) begin
      a_v[i] = 1'b0;
      r_v[i] = 1'b0;
      c_v[i] = 1'b0;
    end
    a_v[inst] = av;
    r_v[inst] = rv;
    c_v[inst] = cv;
  endtask

  // One cycle: drive inputs, record what this cycle must show, advance past the edge.
  task automatic cyc(input int inst, input logic av, input logic rv, input logic cv,
                     input logic eb, input int ep, input logic eo, input string nm);
    exp_t e;
    drive(inst, av, rv, cv);
    e.inst = inst; e.eb = eb; e.epend = ep; e.eovf = eo; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus tables: a, ready, clr, expected b, expected pending (state this cycle), ovf.
  localparam int N_BASIC = 12;
  logic bas_a [N_BASIC] = '{1,0,0,0,1,1,0,0,0,0,0,0};
  logic bas_b [N_BASIC] = '{1,1,0,0,1,1,1,1,0,0,0,0};
  int   bas_p [N_BASIC] = '{0,1,0,0,0,1,2,1,0,0,0,0};

  localparam int N_BP = 6;
  logic bp_a [N_BP] = '{1,0,0,0,0,0};
  logic bp_r [N_BP] = '{0,0,0,1,1,1};
  logic bp_b [N_BP] = '{0,0,0,1,1,0};
  int   bp_p [N_BP] = '{0,2,2,2,1,0};

  localparam int N_SAT = 10;
  logic sat_a [N_SAT] = '{1,1,0,0,0,0,1,1,1,0};
  logic sat_r [N_SAT] = '{0,0,1,1,1,1,0,0,1,0};
  logic sat_c [N_SAT] = '{0,0,0,0,0,0,0,0,1,0};
  logic sat_b [N_SAT] = '{0,0,1,1,1,0,0,0,0,0};
  int   sat_p [N_SAT] = '{0,2,3,2,1,0,0,2,3,0};
  logic sat_o [N_SAT] = '{0,0,1,1,1,1,1,1,1,0};

  initial begin
    int   m_cnt;
    int   total;
    int   nxt;
    int   lost;
    int   sum_a;
    logic m_ovf;
    logic av;
    logic rv;
    logic eb;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < N_BASIC; i++)
      cyc(0, bas_a[i], 1'b1, 1'b0, bas_b[i], bas_p[i], 1'b0, $sformatf("basic[%0d]", i));

    for (int i = 0; i < N_BP; i++)
      cyc(0, bp_a[i], bp_r[i], 1'b0, bp_b[i], bp_p[i], 1'b0, $sformatf("bp[%0d]", i));

    for (int i = 0; i < N_SAT; i++)
      cyc(1, sat_a[i], sat_r[i], sat_c[i], sat_b[i], sat_p[i], sat_o[i],
          $sformatf("sat[%0d]", i));

    // Build cnt=3 on u_f2, then assert rst mid-cycle and look before the next edge.
    cyc(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, "rst_pre0");
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, "rst_pre1");
    drive(0, 1'b1, 1'b0, 1'b0);
    #1 check("rst_pre.pending", int'(p0), 3);
    #2 rst = 1'b1;
    #1;
    check("rst_async.pending",  int'(p0), 0);
    check("rst_async.busy",     int'(busy_v[0]), 0);
    check("rst_async.overflow", int'(ovf_v[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, "rst_post0");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, "rst_post1");
    cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, "rst_post2");

    // FACTOR=1 with ready high: b mirrors a, nothing ever pends.
    for (int i = 0; i < 1000; i++) begin
      av = 1'(($urandom & 1) != 0);
      cyc(2, av, 1'b1, 1'b0, av, 0, 1'b0, "pass");
    end

    // FACTOR=3 against a behavioural model of the credit counter.
    m_cnt = 0; m_ovf = 1'b0; lost = 0; sum_a = 0;
    for (int i = 0; i < 1000; i++) begin
      av    = 1'($urandom_range(0, 3) == 0);
      rv    = 1'($urandom_range(0, 4) != 0);
      total = m_cnt + (av ? 3 : 0);
      eb    = 1'(rv && total > 0);
      cyc(3, av, rv, 1'b0, eb, m_cnt, m_ovf, "f3");
      nxt = total - (eb ? 1 : 0);
      if (nxt > 15) begin
        lost  += nxt - 15;
        m_cnt  = 15;
        m_ovf  = 1'b1;
      end else begin
        m_cnt = nxt;
      end
      if (av) sum_a++;
    end
    drive(3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    check("f3.final_pending", int'(p3), m_cnt);
    check("f3.token_balance", sum_b3, 3 * sum_a - m_cnt - lost);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/token_multiplier.md
Name: token_multiplier

Overview:
Serial token expander, the inverse of the token-halving block. Every '1' on input a is credited as FACTOR output tokens. Tokens are emitted one per cycle on b whenever the downstream is ready. Sits on the single-bit token streams in the sequential-basics group; pending credit is buffered in a saturating counter with sticky overflow.

Parameters:
FACTOR, 2, output tokens generated per input '1' token (1 <= FACTOR <= 2**CNT_W-1; elaboration error otherwise)
CNT_W, 4, width of pending-token counter; max pending MAX = 2**CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
a  input  1  incoming token stream; '1' = one token this cycle
ready  input  1  downstream accepts a token this cycle
clr  input  1  synchronous clear of pending count and overflow flag
b  output  1  outgoing token stream; '1' = one token emitted this cycle
pending  output  CNT_W  registered count of tokens owed (state cnt)
busy  output  1  pending != 0
overflow  output  1  sticky: credit was lost due to saturation

Behaviour:
- Reset clock is clk. rst is asynchronous, active-high. On reset: cnt=0, overflow=0; hence pending=0, busy=0, b=0 (with a=0).
- Per cycle, combinationally: total = cnt + (a ? FACTOR : 0), computed at CNT_W+1 bits.
- b = ready & ~clr & (total != 0). Zero latency: with cnt=0, a=1 and ready=1, b=1 in the same cycle.
- Next state: nxt = total - b.
  - nxt > MAX: cnt <= MAX, overflow <= 1; excess tokens are dropped.
  - Otherwise: cnt <= nxt.
- ready=0: b=0; tokens accumulate in cnt, subject to saturation.
- clr=1, which has priority over a and ready:
  - b=0 that cycle.
  - cnt <= 0, overflow <= 0.
  - The a token in that cycle is discarded.
- overflow stays set until rst or clr.
- FACTOR=1 with ready held at 1 gives b == a (pass-through, cnt stays 0).
- Simultaneous a=1 and emission is legal every cycle. Steady state with a=1 and ready=1 and FACTOR>=2: cnt grows by FACTOR-1 per cycle until it saturates.
- Reset asserted mid-burst drops all pending tokens immediately (async). The first edge after deassertion behaves as from the idle state.
- Example, FACTOR=2, ready=1: a 1000_1100_0000 gives b 1100_1111_0000.

Test Plan:
- Reset: rst pulse with a=1 and cnt=3 -> pending=0, busy=0, overflow=0 immediately, before the next clk edge.
- Basic doubling: FACTOR=2, ready=1, a=1000_1100_0000 -> b=1100_1111_0000; pending=1,0,0,0,1,2,1,0,0…; total '1's on b = 2x '1's on a.
- Backpressure: FACTOR=2, a=1 for 1 cycle with ready=0 for 3 cycles, then ready=1 -> b=0 for 3 cycles, pending=2, then b=1,1,0 and pending=1,0,0.
- Saturation: FACTOR=2, CNT_W=2, ready=0, a=1 for 2 cycles -> pending 2 then 3 (not 4), overflow=1. Then ready=1, a=0 -> exactly 3 b pulses; overflow stays 1.
- Clear priority: pending=3, overflow=1, assert clr with a=1 and ready=1 -> b=0 that cycle; next cycle pending=0, overflow=0, busy=0.
- Pass-through and random: FACTOR=1, ready=1, random a for 1000 cycles -> b==a every cycle, pending=0. Then FACTOR=3 with random a and ready, checked against a reference model: sum(b) = 3·sum(a) - pending, and overflow never set while pending stays < MAX.
